// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with optional Gray output (GRAY_OUT_EN)
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    // Next-state selection: load beats enable; limits are MAX_Q and zero, not natural overflow.
    // A q above MAX_Q can only come from X; it is pulled back into range on the next count.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q = (din > MAX_Q) ? MAX_Q : din;
        end else if (en) begin
            if (up) begin
                if (q < MAX_Q) begin
                    next_q = q + ONE_Q;
                end else if (q == MAX_Q) begin
                    if (!SATURATE) begin
                        next_q    = ZERO_Q;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_q = ZERO_Q;
                end
            end else begin
                if (q > MAX_Q) begin
                    next_q = MAX_Q;
                end else if (q == ZERO_Q) begin
                    if (!SATURATE) begin
                        next_q    = MAX_Q;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_q = q - ONE_Q;
                end
            end
        end
    end

    // Terminal count tracks q and up with no register so a cascaded stage can use en & tc.
    assign tc = (up && (q == MAX_Q)) || (!up && (q == ZERO_Q));

    // Count register and one-cycle wrap pulse; reset has top priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q    <= ZERO_Q;
            wrap <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
        end
    end

`ifdef GRAY_OUT_EN
    // Gray register is fed from next_q so it lands on the same edge as q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_gray <= ZERO_Q;
        end else begin
            q_gray <= next_q ^ (next_q >> 1);
        end
    end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench for param_updown_counter over three configurations
module tb_param_updown_counter;

    typedef struct packed {
        logic [2:0][3:0] q;
        logic [2:0]      w;
        logic [2:0]      t;
        logic            stp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] din;
    logic [3:0] dq [3];
    logic       dw [3];
    logic       dt [3];
    logic [3:0] g  [3];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    int   mq [3];
    int   maxc [3];
    bit   satc [3];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
        .q(dq[0]), .tc(dt[0]), .wrap(dw[0])
`ifdef GRAY_OUT_EN
        , .q_gray(g[0])
`endif
    );
    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
        .q(dq[1]), .tc(dt[1]), .wrap(dw[1])
`ifdef GRAY_OUT_EN
        , .q_gray(g[1])
`endif
    );
    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
        .q(dq[2]), .tc(dt[2]), .wrap(dw[2])
`ifdef GRAY_OUT_EN
        , .q_gray(g[2])
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counting modulo (maxc+1), saturating variant simply refuses to leave the limit.
    function automatic void model(input int mx, input bit sat, input bit r, input bit e,
                                  input bit u, input bit l, input int d,
                                  inout int m, output bit w);
        w = 1'b0;
        if (!r) m = 0;
        else if (l) m = (d > mx) ? mx : d;
        else if (e) begin
            if (u) begin
                if (!(sat && m == mx)) begin
                    w = (m == mx);
                    m = (m + 1) % (mx + 1);
                end
            end else begin
                if (!(sat && m == 0)) begin
                    w = (m == 0);
                    m = (m + mx) % (mx + 1);
                end
            end
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [3:0] d);
        exp_t x;
        bit   w;
        @(negedge clk);
        reset = r; en = e; up = u; load = l; din = d;
        x.stp = r && !l && e;
        for (int i = 0; i < 3; i++) begin
            model(maxc[i], satc[i], r, e, u, l, int'(d), mq[i], w);
            x.q[i] = 4'(mq[i]);
            x.w[i] = w;
            x.t[i] = u ? (mq[i] == maxc[i]) : (mq[i] == 0);
        end
        sb.push_back(x);
    endtask

    // Monitor: one expected entry per active edge, compared 1 time unit after the edge.
    initial begin
        exp_t       e;
        logic [3:0] gprev;
        gprev = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("q%0d", i), int'(dq[i]), int'(e.q[i]));
                    chk($sformatf("wrap%0d", i), int'(dw[i]), int'(e.w[i]));
                    chk($sformatf("tc%0d", i), int'(dt[i]), int'(e.t[i]));
`ifdef GRAY_OUT_EN
                    chk($sformatf("gray%0d", i), int'(g[i]), int'(e.q[i] ^ (e.q[i] >> 1)));
`endif
                end
`ifdef GRAY_OUT_EN
                if (e.stp) chk("gray_one_bit", $countones(g[0] ^ gprev), 1);
                gprev = g[0];
`endif
            end
        end
    end

    initial begin
        maxc = '{15, 9, 9};
        satc = '{1'b0, 1'b0, 1'b1};
        mq   = '{0, 0, 0};
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;

        // reset held two edges with counting requested, then five counts
        repeat (2) step(0, 1, 1, 0, 0);
        repeat (5) step(1, 1, 1, 0, 0);
        // approach and wrap through the top
        step(1, 0, 1, 1, 14);
        repeat (3) step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // down from zero, then clamped load
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 12);
        // saturation limits
        step(1, 0, 1, 1, 9);
        repeat (2) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        repeat (2) step(1, 1, 0, 0, 0);
        // load beats enable, reset mid-count, direction flip
        step(1, 1, 1, 1, 3);
        repeat (2) step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat (3) step(1, 1, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        // full cycle through 0..15 and back to 0
        step(1, 0, 1, 1, 0);
        repeat (17) step(1, 1, 1, 0, 0);
        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(39) != 0, $urandom_range(9) < 7, 1'($urandom),
                 $urandom_range(9) == 0, 4'($urandom));
        end
        @(negedge clk);
        reset = 1'b1; en = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
